// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the FSM state encoding, the funct3 opcode values, the funct7 value that
// selects the M extension, and a helper that flags divides needing no iterations.
package muldiv_pkg;

  localparam int unsigned XlenW = 32;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StMul  = 2'd1;
  localparam state_t StDiv  = 2'd2;
  localparam state_t StDone = 2'd3;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  // Divide by zero, or the single signed overflow case (most negative / -1).
  // Both produce an architecturally fixed result, so the divider is never started.
  function automatic logic div_special(input logic [XlenW-1:0] rs1,
                                       input logic [XlenW-1:0] rs2,
                                       input logic             is_signed);
    logic ovf;
    ovf = is_signed && (rs1 == {1'b1, {(XlenW-1){1'b0}}}) && (rs2 == '1);
    return (rs2 == '0) || ovf;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit.
// master: the requester (issues operands, consumes results).
// slave : the unit itself.
// Request : in_valid, in_ready, rs1, rs2, funct3, funct7, rd_in, flush
// Response: out_valid, out_ready, result, rd_out, div_by_zero, busy
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [XlenW-1:0] rs1;
  logic [XlenW-1:0] rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XlenW-1:0] result;
  logic [4:0]       rd_out;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, rs1, rs2, funct3, funct7, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, rd_out, div_by_zero, busy
  );

  modport slave (
    input  in_valid, rs1, rs2, funct3, funct7, rd_in, flush, out_ready,
    output in_ready, out_valid, result, rd_out, div_by_zero, busy
  );

endinterface

// File: rtl/div_serial.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               load operands and begin Width iterations
//   kill                abandon any operation in flight (wins over start)
//   dividend, divisor   unsigned operands, sampled on start
//   quotient, remainder unsigned results, valid while done is high
//   done                high after the final iteration until the next start/kill
module div_serial #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic [Width-1:0] quotient,
  output logic [Width-1:0] remainder,
  output logic             done
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quot_q, quot_d;
  logic [Width-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  // Partial remainder with the next dividend bit shifted in. It is always below
  // 2*divisor, so a borrow in diff[Width] means "divisor does not fit".
  logic [Width:0] partial;
  logic [Width:0] diff;

  assign partial = {rem_q, quot_q[Width-1]};
  assign diff    = partial - {1'b0, dvs_q};

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = done_q;
    if (kill) begin
      cnt_d  = '0;
      run_d  = 1'b0;
      done_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      rem_d  = diff[Width] ? partial[Width-1:0] : diff[Width-1:0];
      quot_d = {quot_q[Width-2:0], ~diff[Width]};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CntW'(Width - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with a valid/ready request and response.
// Multiplies complete one cycle after accept; divides use div_serial and complete
// 33 cycles after accept (32 iterations plus sign fix-up). Divide by zero and
// signed overflow bypass the divider and complete in one cycle.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       muldiv_unit_if.slave: request (in_valid/in_ready, rs1, rs2, funct3,
//             funct7, rd_in, flush) and response (out_valid/out_ready, result,
//             rd_out, div_by_zero, busy)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [2:0]        f3_q, f3_d;
  logic              ok_q, ok_d;       // funct7 selected the M extension
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              dbz_q, dbz_d;

  logic              out_valid;
  logic              accept;
  logic              req_ok;
  logic              req_div;
  logic              req_signed;
  logic [XLEN-1:0]   dvd_mag;
  logic [XLEN-1:0]   dvs_mag;
  logic              div_start;
  logic              div_done;
  logic [XLEN-1:0]   div_quot;
  logic [XLEN-1:0]   div_rem;

  // Request decode straight off the bus, used on the accept edge.
  assign out_valid  = (state_q == StDone);
  assign accept     = bus.in_valid && (state_q == StIdle) && !bus.flush;
  assign req_ok     = (bus.funct7 == MULDIV_FUNCT7);
  assign req_div    = req_ok && ((bus.funct3 == F3Div) || (bus.funct3 == F3Divu) ||
                                 (bus.funct3 == F3Rem) || (bus.funct3 == F3Remu));
  assign req_signed = (bus.funct3 == F3Div) || (bus.funct3 == F3Rem);
  assign dvd_mag    = (req_signed && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
  assign dvs_mag    = (req_signed && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
  assign div_start  = accept && req_div && !div_special(bus.rs1, bus.rs2, req_signed);

  div_serial #(
    .Width (XLEN)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .kill      (bus.flush),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (div_quot),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Multiply: sign-extend both operands to 2*XLEN; the low 2*XLEN bits of the
  // product are then correct for every signedness combination. MUL takes the low
  // half, which does not depend on the extension chosen.
  logic              a_signed;
  logic              b_signed;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res;

  assign a_signed = (f3_q != F3Mulhu);
  assign b_signed = (f3_q != F3Mulhu) && (f3_q != F3Mulhsu);
  assign mul_a    = {{XLEN{a_signed && rs1_q[XLEN-1]}}, rs1_q};
  assign mul_b    = {{XLEN{b_signed && rs2_q[XLEN-1]}}, rs2_q};
  assign product  = mul_a * mul_b;
  assign mul_res  = (f3_q == F3Mul) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Divide result selection and sign fix-up.
  logic            div_signed;
  logic            rem_sel;
  logic            special_q;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] fix_res;
  logic [XLEN-1:0] special_res;

  assign div_signed  = (f3_q == F3Div) || (f3_q == F3Rem);
  assign rem_sel     = (f3_q == F3Rem) || (f3_q == F3Remu);
  assign special_q   = div_special(rs1_q, rs2_q, div_signed);
  assign q_neg       = div_signed && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
  assign r_neg       = div_signed && rs1_q[XLEN-1];
  assign fix_res     = rem_sel ? (r_neg ? -div_rem : div_rem)
                               : (q_neg ? -div_quot : div_quot);
  // Zero divisor: quotient all ones, remainder = dividend.
  // Overflow: quotient = dividend (most negative), remainder 0.
  assign special_res = (rs2_q == '0) ? (rem_sel ? rs1_q : '1)
                                     : (rem_sel ? '0 : rs1_q);

  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    f3_d     = f3_q;
    ok_d     = ok_q;
    rd_d     = rd_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    if (bus.flush) begin
      state_d = StIdle;
      dbz_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            rs1_d   = bus.rs1;
            rs2_d   = bus.rs2;
            f3_d    = bus.funct3;
            ok_d    = req_ok;
            rd_d    = bus.rd_in;
            // Non-M encodings travel the multiply path and return zero.
            state_d = req_div ? StDiv : StMul;
          end
        end
        StMul: begin
          result_d = ok_q ? mul_res : '0;
          dbz_d    = 1'b0;
          state_d  = StDone;
        end
        StDiv: begin
          if (special_q) begin
            result_d = special_res;
            dbz_d    = (rs2_q == '0);
            state_d  = StDone;
          end else if (div_done) begin
            result_d = fix_res;
            dbz_d    = 1'b0;
            state_d  = StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d = StIdle;
            dbz_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rs1_q    <= '0;
      rs2_q    <= '0;
      f3_q     <= '0;
      ok_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      f3_q     <= f3_d;
      ok_q     <= ok_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.out_valid   = out_valid;
  assign bus.result      = result_q;
  assign bus.rd_out      = rd_q;
  assign bus.div_by_zero = dbz_q && out_valid;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner vectors plus randomized operations,
// expected responses queued at issue and checked by an independent monitor.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  bit   force_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Only this process drives out_ready.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  // Monitor: compare on first sight of out_valid, then check hold while stalled.
  logic [31:0] held_res;
  logic [4:0]  held_rd;
  logic        held_dbz;
  bit          seen = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1, required 0 (t=%0t)", $time);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("result", bus.result, sb[0].res);
          chk("rd_out", 32'(bus.rd_out), 32'(sb[0].rd));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(sb[0].dbz));
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          held_res = bus.result;
          held_rd  = bus.rd_out;
          held_dbz = bus.div_by_zero;
        end else begin
          chk("hold_result", bus.result, held_res);
          chk("hold_rd_out", 32'(bus.rd_out), 32'(held_rd));
          chk("hold_div_by_zero", 32'(bus.div_by_zero), 32'(held_dbz));
        end
        if (bus.out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end else if (bus.div_by_zero) begin
      chk("dbz_without_valid", 32'(bus.div_by_zero), 32'd0);
    end
  end

  // Reference model from the instruction definitions.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, input logic [6:0] f7,
                                output logic [31:0] res, output logic dbz, output int lat);
    logic [127:0] pa, pb, p;
    int x, y;
    res = '0;
    dbz = 1'b0;
    lat = 1;
    if (f7 != MULDIV_FUNCT7) return;
    if (!f3[2]) begin
      pa  = (f3 == F3Mulh || f3 == F3Mulhsu) ? {{96{a[31]}}, a} : {96'b0, a};
      pb  = (f3 == F3Mulh) ? {{96{b[31]}}, b} : {96'b0, b};
      p   = pa * pb;
      res = (f3 == F3Mul) ? p[31:0] : p[63:32];
    end else if (b == 32'd0) begin
      dbz = 1'b1;
      res = (f3 == F3Rem || f3 == F3Remu) ? a : 32'hFFFF_FFFF;
    end else if ((f3 == F3Div || f3 == F3Rem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = (f3 == F3Rem) ? 32'd0 : 32'h8000_0000;
    end else begin
      lat = 33;
      x = $signed(a);
      y = $signed(b);
      case (f3)
        F3Div:   res = 32'(x / y);
        F3Rem:   res = 32'(x % y);
        F3Divu:  res = a / b;
        default: res = a % b;
      endcase
    end
  endfunction

  // Call at posedge+#1. Accept happens on the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input bit push,
                       input logic [31:0] eres, input logic edbz, input int elat);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0, required 1");
      return;
    end
    bus.rs1      = a;
    bus.rs2      = b;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.rd_in    = rd;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) sb.push_back('{eres, rd, edbz, elat, cyc});
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd);
    logic [31:0] r;
    logic        d;
    int          l;
    model(a, b, f3, f7, r, d, l);
    issue(a, b, f3, f7, rd, 1'b1, r, d, l);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic [6:0]  f7;

    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.funct3   = '0;
    bus.funct7   = '0;
    bus.rd_in    = '0;
    rst          = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd_out", 32'(bus.rd_out), 32'd0);
    chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors with hand-computed results.
    issue(32'd7, 32'hFFFF_FFFD, F3Mul, MULDIV_FUNCT7, 5'd1, 1, 32'hFFFF_FFEB, 0, 1); wait_done();
    issue(32'h8000_0000, 32'h8000_0000, F3Mulh, MULDIV_FUNCT7, 5'd2, 1, 32'h4000_0000, 0, 1);
    wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, F3Mulhu, MULDIV_FUNCT7, 5'd3, 1, 32'hFFFF_FFFE, 0, 1);
    wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, F3Mulhsu, MULDIV_FUNCT7, 5'd4, 1, 32'hFFFF_FFFF, 0, 1);
    wait_done();
    issue(32'hFFFF_FFF9, 32'd2, F3Div, MULDIV_FUNCT7, 5'd5, 1, 32'hFFFF_FFFD, 0, 33); wait_done();
    issue(32'hFFFF_FFF9, 32'd2, F3Rem, MULDIV_FUNCT7, 5'd6, 1, 32'hFFFF_FFFF, 0, 33); wait_done();
    issue(32'd100, 32'd0, F3Divu, MULDIV_FUNCT7, 5'd7, 1, 32'hFFFF_FFFF, 1, 1); wait_done();
    issue(32'd100, 32'd0, F3Remu, MULDIV_FUNCT7, 5'd8, 1, 32'd100, 1, 1); wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, F3Div, MULDIV_FUNCT7, 5'd9, 1, 32'h8000_0000, 0, 1);
    wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, F3Rem, MULDIV_FUNCT7, 5'd10, 1, 32'd0, 0, 1); wait_done();
    issue(32'd1234, 32'd0, F3Div, 7'b0100000, 5'd11, 1, 32'd0, 0, 1); wait_done();
    issue(32'd1000, 32'd7, F3Divu, MULDIV_FUNCT7, 5'd12, 1, 32'd142, 0, 33); wait_done();

    // Back-pressure: hold out_ready low for five cycles in DONE.
    force_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(32'd6, 32'd9, F3Mul, MULDIV_FUNCT7, 5'd13, 1, 32'd54, 0, 1);
    @(posedge clk);
    #1;
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    force_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    wait_done();

    // Flush after ten divide iterations: no response may appear.
    issue(32'd5000, 32'd3, F3Div, MULDIV_FUNCT7, 5'd14, 0, 32'd0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    issue(32'd5000, 32'd3, F3Div, MULDIV_FUNCT7, 5'd15, 1, 32'd1666, 0, 33); wait_done();

    // Asynchronous reset in the middle of a divide.
    issue(32'hFFFF_0000, 32'd17, F3Remu, MULDIV_FUNCT7, 5'd16, 0, 32'd0, 0, 0);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rd_out", 32'(bus.rd_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    issue(32'hFFFF_FFF9, 32'd2, F3Div, MULDIV_FUNCT7, 5'd17, 1, 32'hFFFF_FFFD, 0, 33); wait_done();

    // Randomized operations with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : MULDIV_FUNCT7;
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: begin a = 32'($urandom_range(0, 50)); b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: ;
      endcase
      issue_model(a, b, f3, f7, 5'($urandom));
      wait_done();
    end
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept; high only in IDLE.
REQ-006 SHALL have ports rs1, rs2  input  32  source operands.
REQ-007 SHALL have ports funct3 (input, 3) and funct7 (input, 7)  operation select.
REQ-008 SHALL have port rd_in  input  5  destination tag, returned unchanged on rd_out.
REQ-009 SHALL have port flush  input  1  synchronous kill of any in-flight operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports result (output, 32), rd_out (output, 5), div_by_zero (output, 1), busy (output, 1; high when state != IDLE).

Function
REQ-013 SHALL accept a request on a rising edge where in_valid && in_ready && !flush, registering rs1, rs2, funct3, funct7, rd_in.
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE: IDLE->MUL (funct3[2]=0), IDLE->DIV (funct3[2]=1), MUL->DONE, DIV->DONE after final iteration, DONE->IDLE when out_ready.
REQ-015 SHALL treat an accepted request with funct7 != 7'b0000001 as a no-op: go via MUL to DONE with result 0, div_by_zero 0.
REQ-016 SHALL produce MUL (000) = low 32 bits, MULH (001) = high 32 bits signed x signed, MULHSU (010) = high signed rs1 x unsigned rs2, MULHU (011) = high unsigned x unsigned, from a full 64-bit product.
REQ-017 SHALL assert out_valid for multiply ops on the first rising edge after the accept edge (latency 1).
REQ-018 SHALL compute DIV/DIVU/REM/REMU (100/101/110/111) with a 32-iteration radix-2 restoring divider on operand magnitudes; signed ops negate quotient when signs differ and remainder to dividend sign.
REQ-019 SHALL assert out_valid for normal divides exactly 33 rising edges after the accept edge (32 iterations plus sign fix-up).
REQ-020 SHALL on rs2 == 0 skip iterations, set div_by_zero=1, result 0xFFFFFFFF (DIV/DIVU) or rs1 (REM/REMU), latency 1.
REQ-021 SHALL on signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF) skip iterations, return 0x80000000 (DIV) or 0 (REM), div_by_zero 0, latency 1.
REQ-022 SHALL hold out_valid, result, rd_out, div_by_zero stable in DONE until out_ready is sampled high.
REQ-023 SHALL keep in_ready low in MUL, DIV, DONE; no new request accepted on the same edge DONE exits.
REQ-024 SHALL on flush sampled high return to IDLE on that edge, clear out_valid and div_by_zero, discard the operation; flush overrides a simultaneous accept and out_ready.
REQ-025 SHALL deassert div_by_zero whenever out_valid is low.

Reset
REQ-026 SHALL on rst asynchronously force state IDLE, iteration counter 0, out_valid 0, result 0, rd_out 0, div_by_zero 0, busy 0; in_ready high once rst deasserts.
REQ-027 SHALL abandon any in-flight operation on reset mid-operation with no out_valid produced for it.

Structure
REQ-028 SHALL place the state enum, funct3 opcode constants, and MULDIV_FUNCT7 = 7'b0000001 in shared package muldiv_pkg.
REQ-029 SHALL implement the iterative divider datapath (remainder/quotient registers, 5-bit counter) as sub-module div_serial; multiply stays in muldiv_unit.

Verification
REQ-030 SHALL cover MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid one cycle after accept.
REQ-031 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, out_valid exactly 33 cycles after accept, rd_out = rd_in.
REQ-033 SHALL cover DIVU 100 / 0 -> 0xFFFFFFFF, div_by_zero 1; REMU 100 / 0 -> 100; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; all latency 1.
REQ-034 SHALL cover out_ready low 5 cycles in DONE -> outputs stable, in_ready low; then out_ready high -> IDLE next edge.
REQ-035 SHALL cover flush at divide iteration 10 and rst mid-DIV -> IDLE, out_valid never asserted, next request completes correctly.
